player_lives_controller: RTL and testbench
==========================================

Name: player_lives_controller

Overview:
- Central game-state controller that sequences the player datapath: per-frame collision checks of player and sword against enemies, lives counting, hit freeze, respawn request, invulnerability window and game-over.
- Sits between the player movement/attack FSM and the enemy logic.
- Runs on the system clock and advances timers only on the frame tick `trigger`.

Parameters:
- NUM_ENEMIES, 4, number of enemy slots checked each frame.
- LIVES_INIT, 3, lives loaded at reset and on restart; range 1..3.
- HIT_FRAMES, 30, frames frozen after the player is hit.
- INVULN_FRAMES, 60, frames of invulnerability after respawn.
- SPAWN_POS, 8'h13, respawn position in xxxx_yyyy format.

Ports:
- clk, in, 1, system clock.
- reset, in, 1, asynchronous, active-low reset (asserted when 0).
- trigger, in, 1, frame tick; one clk cycle wide.
- start, in, 1, start/restart button, level.
- player_pos, in, 8, player position xxxx_yyyy.
- sword_position, in, 8, sword position xxxx_yyyy.
- sword_visible, in, 4, 4'b0001 = sword shown; any other value = hidden.
- enemy_pos, in, 8*NUM_ENEMIES, packed enemy positions; slot i is at [8i+7:8i].
- enemy_valid, in, NUM_ENEMIES, slot alive.
- lives, out, 2, remaining lives.
- game_state, out, 3, current state encoding.
- enemy_kill, out, NUM_ENEMIES, one-clk pulse per enemy slot struck by the sword.
- respawn_req, out, 1, one-clk pulse requesting the player to move to respawn_pos.
- respawn_pos, out, 8, equals SPAWN_POS.
- freeze, out, 1, high while the player datapath must ignore input.
- player_blink, out, 1, sprite blink enable.
- game_over, out, 1, high in GAME_OVER.

Behaviour:

Reset (reset=0, async) forces:
- state WAIT_START, lives=LIVES_INIT, frame_cnt=0.
- enemy_kill=0, respawn_req=0, freeze=1, player_blink=0, game_over=0.
- Reset mid-operation aborts any timer immediately; no pulses are emitted on reset exit.

Evaluation timing:
- All evaluation happens in the clk cycle where trigger=1, using inputs as sampled that cycle.
- Registered outputs update at the next clk edge.
- Latency from trigger to outputs is 1 clk.
- enemy_kill and respawn_req are exactly one clk wide.
- Cycles with trigger=0 change nothing except returning the pulses to 0.

Collision rules:
- sword_hit[i] = enemy_valid[i] & (sword_visible==4'b0001) & (enemy_pos_i == sword_position).
- player_hit = OR over i of enemy_valid[i] & (enemy_pos_i == player_pos) & ~sword_hit[i].
- Positions are compared as full 8-bit equality; there is no wrap-around arithmetic.

States (all transitions on trigger):
- WAIT_START: freeze=1. start=1 -> PLAY.
- PLAY: freeze=0.
  - enemy_kill <= sword_hit.
  - If player_hit and lives>1: lives-1, frame_cnt=0, -> HIT.
  - If player_hit and lives==1: lives=0, -> GAME_OVER.
- HIT: freeze=1, player_blink=frame_cnt[1]; frame_cnt increments.
  - When frame_cnt==HIT_FRAMES-1: respawn_req pulse, frame_cnt=0, -> INVULN.
  - Kills are not evaluated in HIT.
- INVULN: freeze=0, player_blink=frame_cnt[2]; enemy_kill <= sword_hit; player_hit is ignored.
  - When frame_cnt==INVULN_FRAMES-1: -> PLAY, player_blink=0.
- GAME_OVER: game_over=1, freeze=1.
  - start=1 -> lives=LIVES_INIT, respawn_req pulse, -> PLAY.

Edge cases:
- Simultaneous sword kill and player contact with the same enemy: the kill wins, no life is lost.
- Contact with a different enemy in the same frame still costs a life.
- lives never underflows below 0.
- frame_cnt width is clog2(max(HIT_FRAMES, INVULN_FRAMES)).

Decomposition:
- Shared package holds:
  - the game_state encoding: WAIT_START=0, PLAY=1, HIT=2, INVULN=3, GAME_OVER=4;
  - constants SWORD_SHOWN=4'b0001 and SWORD_HIDDEN=4'b1111;
  - SPAWN_POS default;
  - position field widths (X=[7:4], Y=[3:0]).
- One sub-module, collision_matcher: combinational, NUM_ENEMIES-wide, produces sword_hit[] and player_hit. It is shared with the enemy logic.

Test Plan:
- Reset low for 3 clk, release; start=1 on a trigger -> game_state=PLAY one clk later, lives=3, freeze=0.
- PLAY, enemy0 at 8'h24, player_pos=8'h24, sword hidden, trigger -> lives=2, state=HIT; after 30 triggers -> respawn_req pulse 1 clk, respawn_pos=8'h13, state=INVULN.
- INVULN, enemy on the player for 59 frames -> lives stays 2, player_blink toggles every 4 frames; frame 60 -> PLAY.
- PLAY, sword_visible=4'b0001, sword_position=8'h35, enemy2 at 8'h35 and also on the player -> enemy_kill=4'b0100 for 1 clk, lives unchanged.
- lives=1, player hit -> lives=0, game_over=1, freeze=1; start=1 on a trigger -> lives=3, respawn_req pulse, state=PLAY.
- Assert reset=0 asynchronously mid-HIT at frame 12 -> outputs take reset values before the next clk edge; no respawn_req after release.

Source files
------------

// File: rtl/player_lives_controller_pkg.sv
// Shared types and constants for the player lives controller and its collision matcher.
package player_lives_controller_pkg;

    localparam int unsigned POS_COORD_W = 4;
    localparam int unsigned POS_W       = 2 * POS_COORD_W;
    localparam int unsigned SWORD_VIS_W = 4;
    localparam int unsigned LIVES_W     = 2;
    localparam int unsigned STATE_W     = 3;

    // Position payload: x in [7:4], y in [3:0]
    typedef struct packed {
        logic [POS_COORD_W-1:0] x;
        logic [POS_COORD_W-1:0] y;
    } pos_t;

    localparam logic [SWORD_VIS_W-1:0] SWORD_SHOWN       = 4'b0001;
    localparam logic [SWORD_VIS_W-1:0] SWORD_HIDDEN      = 4'b1111;
    localparam logic [POS_W-1:0]       SPAWN_POS_DEFAULT = 8'h13;

    typedef enum logic [STATE_W-1:0] {
        WAIT_START = 3'd0,
        PLAY       = 3'd1,
        HIT        = 3'd2,
        INVULN     = 3'd3,
        GAME_OVER  = 3'd4
    } game_state_e;

endpackage

// File: rtl/player_lives_controller_collision_matcher.sv
// Combinational per-slot sword/player collision detection; a sword kill masks contact with that slot.
module collision_matcher
    import player_lives_controller_pkg::*;
#(
    parameter int unsigned NUM_ENEMIES = 4
) (
    input  pos_t                           player_pos,
    input  pos_t                           sword_position,
    input  logic [SWORD_VIS_W-1:0]         sword_visible,
    input  logic [POS_W*NUM_ENEMIES-1:0]   enemy_pos,
    input  logic [NUM_ENEMIES-1:0]         enemy_valid,
    output logic [NUM_ENEMIES-1:0]         sword_hit_c,
    output logic                           player_hit_c
);

    logic                   sword_shown;
    logic [NUM_ENEMIES-1:0] contact;

    assign sword_shown = (sword_visible == SWORD_SHOWN);

    for (genvar g = 0; g < NUM_ENEMIES; g++) begin : g_slot
        pos_t enemy;
        assign enemy          = enemy_pos[POS_W*g +: POS_W];
        assign sword_hit_c[g] = enemy_valid[g] & sword_shown & (enemy == sword_position);
        assign contact[g]     = enemy_valid[g] & (enemy == player_pos) & ~sword_hit_c[g];
    end

    assign player_hit_c = |contact;

endmodule

// File: rtl/player_lives_controller.sv
// Game-state sequencer: lives, hit freeze, respawn, invulnerability and game-over, advanced on frame ticks.
module player_lives_controller
    import player_lives_controller_pkg::*;
#(
    parameter int unsigned     NUM_ENEMIES   = 4,
    parameter int unsigned     LIVES_INIT    = 3,
    parameter int unsigned     HIT_FRAMES    = 30,
    parameter int unsigned     INVULN_FRAMES = 60,
    parameter logic [POS_W-1:0] SPAWN_POS    = SPAWN_POS_DEFAULT
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         trigger,
    input  logic                         start,
    input  logic [POS_W-1:0]             player_pos,
    input  logic [POS_W-1:0]             sword_position,
    input  logic [SWORD_VIS_W-1:0]       sword_visible,
    input  logic [POS_W*NUM_ENEMIES-1:0] enemy_pos,
    input  logic [NUM_ENEMIES-1:0]       enemy_valid,
    output logic [LIVES_W-1:0]           lives,
    output logic [STATE_W-1:0]           game_state,
    output logic [NUM_ENEMIES-1:0]       enemy_kill,
    output logic                         respawn_req,
    output logic [POS_W-1:0]             respawn_pos,
    output logic                         freeze,
    output logic                         player_blink,
    output logic                         game_over
);

    localparam int unsigned FRAMES_MAX = (HIT_FRAMES > INVULN_FRAMES) ? HIT_FRAMES : INVULN_FRAMES;
    localparam int unsigned CNT_W      = $clog2(FRAMES_MAX);
    localparam logic [CNT_W-1:0]   HIT_LAST    = CNT_W'(HIT_FRAMES - 1);
    localparam logic [CNT_W-1:0]   INVULN_LAST = CNT_W'(INVULN_FRAMES - 1);
    localparam logic [LIVES_W-1:0] LIVES_RST   = LIVES_W'(LIVES_INIT);

    game_state_e            state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [LIVES_W-1:0]     lives_d;
    logic [NUM_ENEMIES-1:0] kill_d;
    logic                   respawn_d, blink_d, freeze_d, game_over_d;
    logic [NUM_ENEMIES-1:0] sword_hit_c;
    logic                   player_hit_c;

    collision_matcher #(
        .NUM_ENEMIES (NUM_ENEMIES)
    ) u_matcher (
        .player_pos     (player_pos),
        .sword_position (sword_position),
        .sword_visible  (sword_visible),
        .enemy_pos      (enemy_pos),
        .enemy_valid    (enemy_valid),
        .sword_hit_c    (sword_hit_c),
        .player_hit_c   (player_hit_c)
    );

    assign game_state = STATE_W'(state_q);

    // State register and all registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= WAIT_START;
            cnt_q        <= '0;
            lives        <= LIVES_RST;
            enemy_kill   <= '0;
            respawn_req  <= 1'b0;
            respawn_pos  <= SPAWN_POS;
            freeze       <= 1'b1;
            player_blink <= 1'b0;
            game_over    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            lives        <= lives_d;
            enemy_kill   <= kill_d;
            respawn_req  <= respawn_d;
            respawn_pos  <= SPAWN_POS;
            freeze       <= freeze_d;
            player_blink <= blink_d;
            game_over    <= game_over_d;
        end
    end

    // Next-state and output decode; nothing but pulse clearing happens off the frame tick
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        lives_d   = lives;
        kill_d    = '0;
        respawn_d = 1'b0;
        blink_d   = player_blink;

        if (trigger) begin
            unique case (state_q)
                WAIT_START: begin
                    if (start) state_d = PLAY;
                end
                PLAY: begin
                    kill_d = sword_hit_c;
                    if (player_hit_c) begin
                        if (lives > 2'd1) begin
                            lives_d = lives - 2'd1;
                            cnt_d   = '0;
                            blink_d = 1'b0;
                            state_d = HIT;
                        end else begin
                            lives_d = '0;
                            state_d = GAME_OVER;
                        end
                    end
                end
                HIT: begin
                    if (cnt_q == HIT_LAST) begin
                        respawn_d = 1'b1;
                        cnt_d     = '0;
                        blink_d   = 1'b0;
                        state_d   = INVULN;
                    end else begin
                        blink_d = cnt_q[1];
                        cnt_d   = cnt_q + CNT_W'(1);
                    end
                end
                INVULN: begin
                    kill_d = sword_hit_c;
                    if (cnt_q == INVULN_LAST) begin
                        cnt_d   = '0;
                        blink_d = 1'b0;
                        state_d = PLAY;
                    end else begin
                        blink_d = cnt_q[2];
                        cnt_d   = cnt_q + CNT_W'(1);
                    end
                end
                GAME_OVER: begin
                    if (start) begin
                        lives_d   = LIVES_RST;
                        respawn_d = 1'b1;
                        cnt_d     = '0;
                        state_d   = PLAY;
                    end
                end
                default: state_d = WAIT_START;
            endcase
        end

        freeze_d    = (state_d == WAIT_START) || (state_d == HIT) || (state_d == GAME_OVER);
        game_over_d = (state_d == GAME_OVER);
    end

endmodule

// File: tb/tb_player_lives_controller.sv
// Directed test-plan walk plus randomized frames, checked every clock against a frame-level game model.
module tb_player_lives_controller;
    import player_lives_controller_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        trigger;
    logic        start;
    logic [7:0]  player_pos;
    logic [7:0]  sword_position;
    logic [3:0]  sword_visible;
    logic [31:0] enemy_pos;
    logic [3:0]  enemy_valid;
    logic [1:0]  lives;
    logic [2:0]  game_state;
    logic [3:0]  enemy_kill;
    logic        respawn_req;
    logic [7:0]  respawn_pos;
    logic        freeze;
    logic        player_blink;
    logic        game_over;

    int n_vec  = 0;
    int n_miss = 0;

    // Model: 0 wait, 1 play, 2 hit, 3 invuln, 4 game over
    int         m_st;
    int         m_lives;
    int         m_frames;
    logic       m_blink;
    logic       m_resp;
    logic [3:0] m_kill;

    player_lives_controller dut (
        .clk            (clk),
        .reset          (reset),
        .trigger        (trigger),
        .start          (start),
        .player_pos     (player_pos),
        .sword_position (sword_position),
        .sword_visible  (sword_visible),
        .enemy_pos      (enemy_pos),
        .enemy_valid    (enemy_valid),
        .lives          (lives),
        .game_state     (game_state),
        .enemy_kill     (enemy_kill),
        .respawn_req    (respawn_req),
        .respawn_pos    (respawn_pos),
        .freeze         (freeze),
        .player_blink   (player_blink),
        .game_over      (game_over)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_lives = 3; m_frames = 0;
        m_blink = 1'b0; m_resp = 1'b0; m_kill = '0;
    endtask

    task automatic model_step();
        logic [3:0] sh;
        logic       ph;
        logic [7:0] e;
        sh = '0; ph = 1'b0;
        m_kill = '0; m_resp = 1'b0;
        for (int i = 0; i < 4; i++) begin
            e = 8'(enemy_pos >> (8 * i));
            if (enemy_valid[i] && sword_visible == 4'b0001 && e == sword_position)
                sh = sh | (4'b0001 << i);
            else if (enemy_valid[i] && e == player_pos)
                ph = 1'b1;
        end
        if (!trigger) return;
        case (m_st)
            0: if (start) m_st = 1;
            1: begin
                m_kill = sh;
                if (ph) begin
                    if (m_lives > 1) begin m_lives--; m_frames = 0; m_st = 2; end
                    else begin m_lives = 0; m_st = 4; end
                end
            end
            2: begin
                m_frames++;
                if (m_frames == 30) begin m_resp = 1'b1; m_frames = 0; m_blink = 1'b0; m_st = 3; end
                else m_blink = (((m_frames - 1) / 2) % 2) == 1;
            end
            3: begin
                m_kill = sh;
                m_frames++;
                if (m_frames == 60) begin m_frames = 0; m_blink = 1'b0; m_st = 1; end
                else m_blink = (((m_frames - 1) / 4) % 2) == 1;
            end
            default: if (start) begin m_lives = 3; m_resp = 1'b1; m_st = 1; end
        endcase
    endtask

    task automatic compare_all();
        check_eq("game_state", 32'(game_state), 32'(m_st));
        check_eq("lives", 32'(lives), 32'(m_lives));
        check_eq("enemy_kill", 32'(enemy_kill), 32'(m_kill));
        check_eq("respawn_req", 32'(respawn_req), 32'(m_resp));
        check_eq("respawn_pos", 32'(respawn_pos), 32'h13);
        check_eq("freeze", 32'(freeze), 32'(m_st == 0 || m_st == 2 || m_st == 4));
        check_eq("player_blink", 32'(player_blink), 32'(m_blink));
        check_eq("game_over", 32'(game_over), 32'(m_st == 4));
    endtask

    // Called #1 after a rising edge: model then DUT advance one clock
    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    // Pull reset low between edges and expect immediate reset values
    task automatic async_reset();
        #3 reset = 1'b0;
        #1;
        model_reset();
        compare_all();
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        reset = 1'b1;
    endtask

    task automatic set_idle();
        trigger = 1'b0; start = 1'b0;
        player_pos = 8'h00; sword_position = 8'h00;
        sword_visible = SWORD_HIDDEN;
        enemy_pos = '0; enemy_valid = '0;
    endtask

    task automatic hit_player();
        enemy_valid = 4'b0001; enemy_pos = 32'h0000_0024; player_pos = 8'h24;
        sword_visible = SWORD_HIDDEN; trigger = 1'b1;
        step();
        enemy_valid = '0;
    endtask

    logic [7:0] pool [4] = '{8'h24, 8'h35, 8'h13, 8'h57};

    initial begin
        set_idle();
        reset = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        compare_all();
        reset = 1'b1;
        trigger = 1'b0;
        step();

        // Start from the waiting screen
        start = 1'b1; trigger = 1'b1;
        step();
        check_eq("tp_play_state", 32'(game_state), 32'd1);
        check_eq("tp_play_freeze", 32'(freeze), 32'd0);
        start = 1'b0;

        // Contact with enemy0 costs a life, then 30 frozen frames
        hit_player();
        check_eq("tp_hit_lives", 32'(lives), 32'd2);
        repeat (30) step();
        check_eq("tp_respawn_pulse", 32'(respawn_req), 32'd1);
        check_eq("tp_invuln_state", 32'(game_state), 32'd3);
        trigger = 1'b0;
        step();
        check_eq("tp_respawn_clear", 32'(respawn_req), 32'd0);

        // Invulnerable while standing on an enemy for the whole window
        enemy_valid = 4'b0001; enemy_pos = 32'h0000_0024; player_pos = 8'h24; trigger = 1'b1;
        repeat (59) step();
        check_eq("tp_invuln_lives", 32'(lives), 32'd2);
        step();
        check_eq("tp_back_to_play", 32'(game_state), 32'd1);

        // Sword kill on enemy2 while the player touches it: no life lost
        enemy_valid = 4'b0100; enemy_pos = 32'h0035_0000; player_pos = 8'h35;
        sword_position = 8'h35; sword_visible = SWORD_SHOWN; trigger = 1'b1;
        step();
        check_eq("tp_kill_slot2", 32'(enemy_kill), 32'b0100);
        check_eq("tp_kill_lives", 32'(lives), 32'd2);
        trigger = 1'b0;
        step();

        // Burn through the remaining lives to game over, then restart
        hit_player();
        repeat (90) step();
        hit_player();
        check_eq("tp_go_lives", 32'(lives), 32'd0);
        check_eq("tp_go_flag", 32'(game_over), 32'd1);
        start = 1'b1; trigger = 1'b1;
        step();
        check_eq("tp_restart_lives", 32'(lives), 32'd3);
        check_eq("tp_restart_resp", 32'(respawn_req), 32'd1);
        start = 1'b0;

        // Reset lands mid-HIT at frame 12
        hit_player();
        repeat (12) step();
        async_reset();
        trigger = 1'b0;
        repeat (3) step();
        check_eq("tp_no_resp_after_rst", 32'(respawn_req), 32'd0);

        // Randomized frames
        for (int n = 0; n < 6000; n++) begin
            trigger        = ($urandom % 2) == 0;
            start          = ($urandom % 8) == 0;
            player_pos     = pool[$urandom % 4];
            sword_position = pool[$urandom % 4];
            case ($urandom % 4)
                0, 1:    sword_visible = SWORD_SHOWN;
                2:       sword_visible = SWORD_HIDDEN;
                default: sword_visible = 4'($urandom);
            endcase
            for (int i = 0; i < 4; i++)
                enemy_pos[8*i +: 8] = pool[$urandom % 4];
            enemy_valid = 4'($urandom);
            step();
            if ($urandom % 700 == 0) async_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
